daric_cfg_sequencer: RTL

Host-side configuration and run sequencer for the Daric array. It accepts a stream of 28-bit instruction words over a valid/ready handshake and drives the 39-bit `host_controller` word in three phases: scratchpad init, then each of the 9 PE-array init lanes in turn, then a timed run window. It sits between the external host/DMA and the Daric top level, and replaces hand-driven testbench sequencing of `run`/`init_SPM`/`init_PE_array`.

---
 rtl/daric_cfg_sequencer_pkg.sv | 29 ++
 rtl/daric_cfg_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/daric_cfg_sequencer_pkg.sv
// Shared definitions for the Daric configuration sequencer: state encoding,
// host_controller field layout and the phase-selection helper.
package daric_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_SPM = 3'd1,
    ST_LOAD_PE  = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_t;

  // host_controller = {run, init_SPM, init_PE_array[8:0], instruction[27:0]}
  localparam int H_C_W   = 39;
  localparam int RUN_BIT = 38;
  localparam int SPM_BIT = 37;
  localparam int PE_LSB  = 28;

  // First phase that still has work, in the fixed order SPM, PE, RUN.
  function automatic seq_state_t first_phase(input logic spm_nz,
                                             input logic pe_nz,
                                             input logic run_nz);
    if (spm_nz)      return ST_LOAD_SPM;
    else if (pe_nz)  return ST_LOAD_PE;
    else if (run_nz) return ST_RUN;
    else             return ST_DONE;
  endfunction

endpackage

// File: rtl/daric_cfg_sequencer.sv
// Daric host-side configuration/run sequencer. Streams instruction words into
// the SPM and then each PE-array init lane, then holds run high for a timed
// window. Optional macro DARIC_CFG_SEQ_ABORT_EN adds an abort input and a
// sticky aborted flag.
module daric_cfg_sequencer
  import daric_cfg_sequencer_pkg::*;
#(
  parameter int INST_W   = 28,
  parameter int PE_LANES = 9,
  parameter int CNT_W    = 8,
  parameter int RUN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    spm_words,
  input  logic [CNT_W-1:0]    pe_words,
  input  logic [RUN_W-1:0]    run_cycles,
  input  logic                inst_valid,
  input  logic [INST_W-1:0]   inst_data,
  output logic                inst_ready,
  output logic [INST_W+10:0]  host_controller,
  output logic                busy,
`ifdef DARIC_CFG_SEQ_ABORT_EN
  input  logic                abort,
  output logic                aborted,
`endif
  output logic                done
);

  localparam int LANE_W = (PE_LANES > 1) ? $clog2(PE_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PE_LANES - 1);

  seq_state_t state_q, state_d;

  logic [CNT_W-1:0]    spm_len_q, pe_len_q, word_cnt_q;
  logic [RUN_W-1:0]    run_len_q, run_cnt_q;
  logic [LANE_W-1:0]   lane_q;
  logic                run_q, spm_q;
  logic [PE_LANES-1:0] pe_q;
  logic [INST_W-1:0]   instr_q;
  logic [H_C_W-1:0]    hc;

  logic load_phase, xfer, abort_req;
  logic spm_last, pe_word_last, run_last;
  logic [PE_LANES-1:0] lane_oh;

  assign load_phase   = (state_q == ST_LOAD_SPM) || (state_q == ST_LOAD_PE);
  assign xfer         = inst_valid & load_phase;
  assign spm_last     = (word_cnt_q == spm_len_q - CNT_W'(1));
  assign pe_word_last = (word_cnt_q == pe_len_q - CNT_W'(1));
  assign run_last     = (run_cnt_q == run_len_q - RUN_W'(1));
  assign lane_oh      = PE_LANES'(1) << lane_q;

`ifdef DARIC_CFG_SEQ_ABORT_EN
  assign abort_req = abort & (state_q != ST_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and state-decoded handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    inst_ready = load_phase;
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE:
        if (start)
          state_d = first_phase(spm_words != '0, pe_words != '0, run_cycles != '0);
      ST_LOAD_SPM:
        if (xfer && spm_last)
          state_d = first_phase(1'b0, pe_len_q != '0, run_len_q != '0);
      ST_LOAD_PE:
        if (xfer && pe_word_last && (lane_q == LAST_LANE))
          state_d = first_phase(1'b0, 1'b0, run_len_q != '0);
      ST_RUN:
        if (run_last) state_d = ST_DONE;
      ST_DONE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    if (abort_req) state_d = ST_IDLE;
  end

  // Latched counts and the word/lane/run counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spm_len_q  <= '0;
      pe_len_q   <= '0;
      run_len_q  <= '0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      run_cnt_q  <= '0;
    end else if (abort_req) begin
      word_cnt_q <= '0;
      lane_q     <= '0;
      run_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (start) begin
            spm_len_q  <= spm_words;
            pe_len_q   <= pe_words;
            run_len_q  <= run_cycles;
            word_cnt_q <= '0;
            lane_q     <= '0;
            run_cnt_q  <= '0;
          end
        ST_LOAD_SPM:
          if (xfer) word_cnt_q <= spm_last ? '0 : word_cnt_q + CNT_W'(1);
        ST_LOAD_PE:
          if (xfer) begin
            if (pe_word_last) begin
              word_cnt_q <= '0;
              lane_q     <= (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
            end else begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
          end
        ST_RUN:
          run_cnt_q <= run_last ? '0 : run_cnt_q + RUN_W'(1);
        default: ;
      endcase
    end
  end

  // Registered host_controller fields; init bits pulse for one cycle per word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q   <= 1'b0;
      spm_q   <= 1'b0;
      pe_q    <= '0;
      instr_q <= '0;
    end else begin
      run_q <= (state_d == ST_RUN);
      spm_q <= xfer && !abort_req && (state_q == ST_LOAD_SPM);
      pe_q  <= (xfer && !abort_req && (state_q == ST_LOAD_PE)) ? lane_oh : '0;
      if (xfer && !abort_req) instr_q <= inst_data;
    end
  end

`ifdef DARIC_CFG_SEQ_ABORT_EN
  // Sticky abort flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              aborted <= 1'b0;
    else if (abort_req)                    aborted <= 1'b1;
    else if (state_q == ST_IDLE && start)  aborted <= 1'b0;
  end
`endif

  // Pack the fields into the top-level host_controller layout.
  always_comb begin
    hc                        = '0;
    hc[RUN_BIT]               = run_q;
    hc[SPM_BIT]               = spm_q;
    hc[PE_LSB +: PE_LANES]    = pe_q;
    hc[INST_W-1:0]            = instr_q;
  end

  assign host_controller = hc;

endmodule
